// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Three-master / single-slave memory port arbiter. m0 has fixed
//               top priority, m1 and m2 share round-robin. One transaction is
//               in flight at a time; a per-phase timeout answers a hung slave
//               with an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              TO_W     = 8,
    parameter int              TIMEOUT  = 255,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         m_req,
    input  logic [2:0]         m_we,
    input  logic [3*AW-1:0]    m_addr,
    input  logic [3*DW-1:0]    m_wdata,
    output logic [2:0]         m_gnt,
    output logic [2:0]         m_rvalid,
    output logic [2:0]         m_err,
    output logic [DW-1:0]      m_rdata,
    output logic               s_req,
    output logic               s_we,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    input  logic               s_ready,
    input  logic               s_rvalid,
    input  logic [DW-1:0]      s_rdata,
    output logic [1:0]         owner,
    output logic               busy
);

    localparam logic [1:0]      c_IDLE    = 2'd0;
    localparam logic [1:0]      c_REQ     = 2'd1;
    localparam logic [1:0]      c_RESP    = 2'd2;
    localparam logic [1:0]      c_NOBODY  = 2'd3;
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [1:0]      r_owner;
    logic            r_rr_last_m2;   // 1: m2 was the last of m1/m2 granted
    logic [TO_W-1:0] r_cnt;

    logic [1:0]      w_winner;
    logic [2:0]      w_owner_oh;
    logic            w_sel_we;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_cnt_last;
    logic            w_req_done;
    logic            w_req_to;
    logic            w_resp_done;
    logic            w_resp_to;
    logic            w_gnt;
    logic            w_rv;
    logic            w_err;

    // Pick the next owner: m0 fixed priority, m1/m2 alternate on contention
    always_comb begin
        w_winner = c_NOBODY;
        if (m_req[0]) begin
            w_winner = 2'd0;
        end else if (m_req[1] && m_req[2]) begin
            w_winner = r_rr_last_m2 ? 2'd1 : 2'd2;
        end else if (m_req[1]) begin
            w_winner = 2'd1;
        end else if (m_req[2]) begin
            w_winner = 2'd2;
        end
    end

    // Route the owning master's request fields toward the slave
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        case (r_owner)
            2'd0: begin
                w_sel_we    = m_we[0];
                w_sel_addr  = m_addr[0*AW +: AW];
                w_sel_wdata = m_wdata[0*DW +: DW];
            end
            2'd1: begin
                w_sel_we    = m_we[1];
                w_sel_addr  = m_addr[1*AW +: AW];
                w_sel_wdata = m_wdata[1*DW +: DW];
            end
            2'd2: begin
                w_sel_we    = m_we[2];
                w_sel_addr  = m_addr[2*AW +: AW];
                w_sel_wdata = m_wdata[2*DW +: DW];
            end
            default: ;
        endcase
    end

    // Completion beats timeout when both land in the same cycle
    assign w_cnt_last  = (r_cnt == c_TO_LAST);
    assign w_req_done  = (r_state == c_REQ)  &&  s_ready;
    assign w_req_to    = (r_state == c_REQ)  && !s_ready  && w_cnt_last;
    assign w_resp_done = (r_state == c_RESP) &&  s_rvalid;
    assign w_resp_to   = (r_state == c_RESP) && !s_rvalid && w_cnt_last;

    // Transaction sequencer: arbitration, request phase, response phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_owner      <= c_NOBODY;
            r_rr_last_m2 <= 1'b1;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|m_req) begin
                        r_owner <= w_winner;
                        r_state <= c_REQ;
                        r_cnt   <= '0;
                        if (w_winner != 2'd0) begin
                            r_rr_last_m2 <= (w_winner == 2'd2);
                        end
                    end
                end
                c_REQ: begin
                    if (w_req_done && !w_sel_we) begin
                        r_state <= c_RESP;
                        r_cnt   <= '0;
                    end else if (w_req_done || w_req_to) begin
                        r_state <= c_IDLE;
                        r_owner <= c_NOBODY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RESP: begin
                    if (w_resp_done || w_resp_to) begin
                        r_state <= c_IDLE;
                        r_owner <= c_NOBODY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_owner <= c_NOBODY;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Per-master pulses decode straight off state, owner and slave inputs
    assign w_owner_oh = 3'b001 << r_owner;
    assign w_gnt      = w_req_done | w_req_to;
    assign w_rv       = w_resp_done | w_resp_to | (w_req_to & ~w_sel_we);
    assign w_err      = w_req_to | w_resp_to;

    assign m_gnt    = w_owner_oh & {3{w_gnt}};
    assign m_rvalid = w_owner_oh & {3{w_rv}};
    assign m_err    = w_owner_oh & {3{w_err}};
    assign m_rdata  = w_resp_done ? s_rdata  :
                      w_rv        ? ERR_DATA : '0;

    assign s_req   = (r_state == c_REQ);
    assign s_we    = s_req & w_sel_we;
    assign s_addr  = s_req ? w_sel_addr  : '0;
    assign s_wdata = s_req ? w_sel_wdata : '0;

    assign owner = r_owner;
    assign busy  = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed and randomized bench for mem_bus_arbiter with a
//               transaction-level reference model (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int          c_TO  = 4;
    localparam logic [31:0] c_ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_req, m_we, m_gnt, m_rvalid, m_err;
    logic [95:0] m_addr, m_wdata;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic        s_req, s_we, s_ready, s_rvalid, busy;
    logic [1:0]  owner;

    // Model state: pending master requests and round-robin memory
    logic [2:0]  p_req;
    logic [2:0]  p_we;
    logic [31:0] p_addr [3];
    logic [31:0] p_wd   [3];
    bit          mdl_last_m2;

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(
        .AW(32), .DW(32), .TO_W(8), .TIMEOUT(c_TO), .ERR_DATA(c_ERR)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m();
        m_req = p_req;
        m_we  = p_we;
        for (int i = 0; i < 3; i++) begin
            m_addr[i*32 +: 32]  = p_addr[i];
            m_wdata[i*32 +: 32] = p_wd[i];
        end
    endtask

    task automatic raise(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
        p_req[i] = 1'b1;
        p_we[i]  = we;
        p_addr[i] = a;
        p_wd[i]  = d;
    endtask

    // One full transaction from its IDLE arbitration cycle back to IDLE.
    // d: REQ cycle on which the slave accepts; lat: RESP cycle carrying data.
    // Either one at or beyond c_TO means that phase runs into the timeout.
    task automatic do_txn(input int d, input int lat, input logic [31:0] rd, input bit stale);
        int w;
        logic [2:0] oh;
        bit done, fin, to, req_to;
        if (p_req[0])                    w = 0;
        else if (p_req[1] && p_req[2])   w = mdl_last_m2 ? 1 : 2;
        else if (p_req[1])               w = 1;
        else                             w = 2;
        oh = 3'b001 << w;
        req_to = 1'b0;

        drive_m();
        s_ready = stale; s_rvalid = stale; s_rdata = $urandom;
        #3;
        chk("idle_busy",   busy,     0);
        chk("idle_owner",  owner,    3);
        chk("idle_sreq",   s_req,    0);
        chk("idle_gnt",    m_gnt,    0);
        chk("idle_rvalid", m_rvalid, 0);
        chk("idle_rdata",  m_rdata,  0);
        @(posedge clk); #1;
        if (w != 0) mdl_last_m2 = (w == 2);

        done = 1'b0;
        for (int k = 0; k < c_TO && !done; k++) begin
            s_ready = (k == d); s_rvalid = stale; s_rdata = $urandom;
            #3;
            fin = (k == d);
            to  = !fin && (k == c_TO - 1);
            chk("req_owner",  owner,   w);
            chk("req_busy",   busy,    1);
            chk("req_sreq",   s_req,   1);
            chk("req_swe",    s_we,    p_we[w]);
            chk("req_saddr",  s_addr,  p_addr[w]);
            chk("req_swdata", s_wdata, p_wd[w]);
            chk("req_gnt",    m_gnt,    (fin || to) ? oh : 3'b000);
            chk("req_err",    m_err,    to ? oh : 3'b000);
            chk("req_rvalid", m_rvalid, (to && !p_we[w]) ? oh : 3'b000);
            chk("req_rdata",  m_rdata,  (to && !p_we[w]) ? c_ERR : 32'h0);
            @(posedge clk); #1;
            if (fin || to) begin
                done = 1'b1;
                req_to = to;
                p_req[w] = 1'b0;
                drive_m();
            end
        end

        if (!p_we[w] && !req_to) begin
            done = 1'b0;
            for (int k = 0; k < c_TO && !done; k++) begin
                s_ready = 1'($urandom); s_rvalid = (k == lat);
                s_rdata = (k == lat) ? rd : $urandom;
                #3;
                fin = (k == lat);
                to  = !fin && (k == c_TO - 1);
                chk("resp_owner",  owner,   w);
                chk("resp_busy",   busy,    1);
                chk("resp_sreq",   s_req,   0);
                chk("resp_saddr",  s_addr,  0);
                chk("resp_swe",    s_we,    0);
                chk("resp_gnt",    m_gnt,   0);
                chk("resp_rvalid", m_rvalid, (fin || to) ? oh : 3'b000);
                chk("resp_err",    m_err,    to ? oh : 3'b000);
                chk("resp_rdata",  m_rdata,  fin ? rd : (to ? c_ERR : 32'h0));
                @(posedge clk); #1;
                if (fin || to) done = 1'b1;
            end
        end
        s_ready = 1'b0; s_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        p_req = '0; p_we = '0;
        for (int i = 0; i < 3; i++) begin p_addr[i] = '0; p_wd[i] = '0; end
        drive_m();
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        mdl_last_m2 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_owner",  owner,    3);
        chk("rst_busy",   busy,     0);
        chk("rst_sreq",   s_req,    0);
        chk("rst_gnt",    m_gnt,    0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_err",    m_err,    0);
        chk("rst_rdata",  m_rdata,  0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write from m1, accepted immediately
        raise(1, 1'b1, 32'h100, 32'h12345678);
        do_txn(0, 0, 32'h0, 1'b0);

        // Single read from m2, data three cycles after accept
        raise(2, 1'b0, 32'h0, 32'h0);
        do_txn(0, 2, 32'hCAFEF00D, 1'b0);

        // Three-way contention, then m1/m2 keep requesting
        raise(0, 1'b1, 32'h200, 32'hA0A0A0A0);
        raise(1, 1'b1, 32'h204, 32'hA1A1A1A1);
        raise(2, 1'b1, 32'h208, 32'hA2A2A2A2);
        for (int j = 0; j < 3; j++) do_txn(0, 0, 32'h0, 1'b0);
        raise(1, 1'b1, 32'h300, 32'hB1B1B1B1);
        raise(2, 1'b1, 32'h304, 32'hB2B2B2B2);
        for (int j = 0; j < 4; j++) begin
            do_txn(0, 0, 32'h0, 1'b0);
            if (j < 3) begin
                if (!p_req[1]) raise(1, 1'b1, 32'h310 + j, 32'hC1C1C100 + j);
                if (!p_req[2]) raise(2, 1'b1, 32'h320 + j, 32'hC2C2C200 + j);
            end
        end
        do_txn(0, 0, 32'h0, 1'b0);

        // Response timeout on an m1 read, then stale s_rvalid afterwards
        raise(1, 1'b0, 32'h40, 32'h0);
        do_txn(0, 99, 32'h0, 1'b0);
        raise(0, 1'b1, 32'h44, 32'h55AA55AA);
        do_txn(1, 0, 32'h0, 1'b1);

        // Completion on the last allowed cycle of each phase
        raise(1, 1'b1, 32'h48, 32'h0BADF00D);
        do_txn(c_TO - 1, 0, 32'h0, 1'b1);
        raise(2, 1'b0, 32'h4C, 32'h0);
        do_txn(c_TO - 1, c_TO - 1, 32'h13572468, 1'b0);

        // Request-phase timeouts for a write and a read
        raise(0, 1'b1, 32'h50, 32'h11112222);
        do_txn(99, 0, 32'h0, 1'b0);
        raise(1, 1'b0, 32'h54, 32'h0);
        do_txn(99, 0, 32'h0, 1'b0);

        // Asynchronous reset while waiting for read data
        raise(2, 1'b0, 32'h60, 32'h0);
        drive_m();
        #3; @(posedge clk); #1;
        s_ready = 1'b1;
        #3;
        chk("rstx_gnt", m_gnt, 3'b100);
        @(posedge clk); #1;
        s_ready = 1'b0;
        #2; rst = 1'b1; #1;
        chk("rstx_sreq",  s_req,    0);
        chk("rstx_busy",  busy,     0);
        chk("rstx_owner", owner,    3);
        chk("rstx_rv",    m_rvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_last_m2 = 1'b1;
        do_txn(0, 1, 32'h600DDA7A, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!p_req[i] && ($urandom_range(3) < ((i == 0) ? 1 : 2)))
                    raise(i, 1'($urandom), $urandom, $urandom);
            end
            if (p_req == 3'b000) raise(1 + $urandom_range(1), 1'($urandom), $urandom, $urandom);
            do_txn($urandom_range(5), $urandom_range(5), $urandom, 1'($urandom));
        end

        #3;
        chk("end_busy", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
